// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C write arbiter and its helpers.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LAUNCH     = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_RESPOND    = 3'd4,
        ST_HOLDOFF    = 3'd5
    } arbState_t;

endpackage

// File: rtl/i2c_cycle_timer.sv
// Clear/enable counter that raises terminal once LIMIT-1 counts have elapsed and then holds.
module i2c_cycle_timer #(
    parameter int LIMIT = 16,
    localparam int CW = $clog2(LIMIT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/i2c_write_arbiter.sv
// Two-requester arbiter in front of the I2C byte-write control unit.
// Optional NACK retry is compiled in with the I2C_ARB_RETRY_EN macro.
module i2c_write_arbiter
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int HOLDOFF_CYCLES = 250,
    parameter int MAX_RETRY      = 2
) (
    input  logic                  clock,
    input  logic                  Reset,
    input  logic                  ReqA,
    input  logic [I2C_ADDR_W-1:0] AddrA,
    input  logic [I2C_DATA_W-1:0] DataA,
    input  logic                  ReqB,
    input  logic [I2C_ADDR_W-1:0] AddrB,
    input  logic [I2C_DATA_W-1:0] DataB,
    output logic                  GntA,
    output logic                  GntB,
    output logic                  DoneA,
    output logic                  DoneB,
    output logic                  Nack,
    output logic                  Go,
    output logic [I2C_ADDR_W-1:0] TxAddr,
    output logic [I2C_DATA_W-1:0] TxData,
    input  logic                  Busy,
    input  logic                  AckError,
    output logic [2:0]            DebugState
);

    // Handshake: a requester raises Req and holds it until its one-cycle Done
    // (with Nack alongside); downstream, Go launches one byte write and Busy
    // brackets it, with AckError valid on the cycle Busy falls.

    if (TIMEOUT_CYCLES < 16 || HOLDOFF_CYCLES < 1 || MAX_RETRY < 0) begin : gParamCheck
        $error("i2c_write_arbiter: parameter out of range");
    end

    arbState_t state, stateNext;

    logic ownerIsB;
    logic prefA;
    logic nackReg;
    logic inTxn;
    logic grantNow, grantB;
    logic finishNow, finishNack;
    logic timeoutHit, holdoffDone;

`ifdef I2C_ARB_RETRY_EN
    logic [7:0] retryCount;
    logic       retryPending;
    logic       retryNow;
`endif

    assign inTxn = (state == ST_LAUNCH) || (state == ST_WAIT_START) || (state == ST_WAIT_DONE);

    // Timeout window starts at LAUNCH and covers both wait states.
    i2c_cycle_timer #(.LIMIT(TIMEOUT_CYCLES)) uTimeout (
        .clock   (clock),
        .reset   (Reset),
        .clear   (!inTxn),
        .enable  (inTxn),
        .terminal(timeoutHit)
    );

    i2c_cycle_timer #(.LIMIT(HOLDOFF_CYCLES)) uHoldoff (
        .clock   (clock),
        .reset   (Reset),
        .clear   (state != ST_HOLDOFF),
        .enable  (state == ST_HOLDOFF),
        .terminal(holdoffDone)
    );

    always_ff @(posedge clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        grantNow   = 1'b0;
        grantB     = 1'b0;
        finishNow  = 1'b0;
        finishNack = 1'b0;
`ifdef I2C_ARB_RETRY_EN
        retryNow   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                // A control unit still busy from elsewhere blocks any grant.
                if (!Busy && (ReqA || ReqB)) begin
                    grantNow  = 1'b1;
                    grantB    = ReqB && (!ReqA || !prefA);
                    stateNext = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                stateNext = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (timeoutHit) begin
                    finishNow  = 1'b1;
                    finishNack = 1'b1;
                    stateNext  = ST_RESPOND;
                end else if (Busy) begin
                    stateNext = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!Busy) begin
`ifdef I2C_ARB_RETRY_EN
                    if (AckError && (retryCount < 8'(MAX_RETRY))) begin
                        retryNow  = 1'b1;
                        stateNext = ST_HOLDOFF;
                    end else begin
                        finishNow  = 1'b1;
                        finishNack = AckError;
                        stateNext  = ST_RESPOND;
                    end
`else
                    finishNow  = 1'b1;
                    finishNack = AckError;
                    stateNext  = ST_RESPOND;
`endif
                end else if (timeoutHit) begin
                    finishNow  = 1'b1;
                    finishNack = 1'b1;
                    stateNext  = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                stateNext = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (holdoffDone) begin
`ifdef I2C_ARB_RETRY_EN
                    stateNext = retryPending ? ST_LAUNCH : ST_IDLE;
`else
                    stateNext = ST_IDLE;
`endif
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            TxAddr   <= '0;
            TxData   <= '0;
            ownerIsB <= 1'b0;
            prefA    <= 1'b1;
            nackReg  <= 1'b0;
        end else begin
            if (grantNow) begin
                ownerIsB <= grantB;
                TxAddr   <= grantB ? AddrB : AddrA;
                TxData   <= grantB ? DataB : DataA;
            end
            if (finishNow) begin
                nackReg <= finishNack;
            end
            // Whoever was just served loses the next tie.
            if (state == ST_RESPOND) begin
                prefA <= ownerIsB;
            end
        end
    end

`ifdef I2C_ARB_RETRY_EN
    always_ff @(posedge clock) begin
        if (Reset) begin
            retryCount   <= '0;
            retryPending <= 1'b0;
        end else begin
            if (grantNow) begin
                retryCount <= '0;
            end else if (retryNow) begin
                retryCount <= retryCount + 1'b1;
            end
            if (retryNow) begin
                retryPending <= 1'b1;
            end else if (state == ST_HOLDOFF && holdoffDone) begin
                retryPending <= 1'b0;
            end
        end
    end
`endif

    assign GntA       = inTxn && !ownerIsB;
    assign GntB       = inTxn && ownerIsB;
    assign Go         = (state == ST_LAUNCH);
    assign DoneA      = (state == ST_RESPOND) && !ownerIsB;
    assign DoneB      = (state == ST_RESPOND) && ownerIsB;
    assign Nack       = (state == ST_RESPOND) && nackReg;
    assign DebugState = state;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Directed bench for i2c_write_arbiter; retry expectations follow I2C_ARB_RETRY_EN.
module tb_i2c_write_arbiter;

    localparam int TIMEOUT_CYCLES = 4096;
    localparam int HOLDOFF_CYCLES = 250;
    localparam int MAX_RETRY      = 2;

    logic       clock = 1'b0;
    logic       Reset;
    logic       ReqA, ReqB;
    logic [6:0] AddrA, AddrB;
    logic [7:0] DataA, DataB;
    logic       GntA, GntB, DoneA, DoneB, Nack, Go;
    logic [6:0] TxAddr;
    logic [7:0] TxData;
    logic       Busy, AckError;
    logic [2:0] DebugState;

    int testsRun    = 0;
    int testsFailed = 0;
    int gntViol     = 0;
    int doneViol    = 0;
    logic [2:0] expQ[$];

    i2c_write_arbiter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .clock     (clock),
        .Reset     (Reset),
        .ReqA      (ReqA),
        .AddrA     (AddrA),
        .DataA     (DataA),
        .ReqB      (ReqB),
        .AddrB     (AddrB),
        .DataB     (DataB),
        .GntA      (GntA),
        .GntB      (GntB),
        .DoneA     (DoneA),
        .DoneB     (DoneB),
        .Nack      (Nack),
        .Go        (Go),
        .TxAddr    (TxAddr),
        .TxData    (TxData),
        .Busy      (Busy),
        .AckError  (AckError),
        .DebugState(DebugState)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Scoreboard: every Done pulse must match the next expected {DoneB,DoneA,Nack}.
    always @(negedge clock) begin
        logic [2:0] exp;
        if (GntA && GntB) gntViol++;
        if (DoneA && DoneB) doneViol++;
        if (DoneA || DoneB) begin
            if (expQ.size() == 0) begin
                checkEq("unexpected_done", {DoneB, DoneA, Nack}, 3'b000);
            end else begin
                exp = expQ.pop_front();
                checkEq("done_resp", {DoneB, DoneA, Nack}, exp);
            end
        end
    end

    task automatic resetDut();
        Reset = 1'b1; ReqA = 1'b0; ReqB = 1'b0; Busy = 1'b0; AckError = 1'b0;
        repeat (2) @(negedge clock);
        checkEq("reset_outs", {GntA, GntB, DoneA, DoneB, Nack, Go, TxAddr, TxData, DebugState}, 0);
        Reset = 1'b0;
    endtask

    task automatic waitGo(input int limit, output bit seen, output int lat);
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clock);
            lat++;
            if (Go) seen = 1'b1;
        end
    endtask

    task automatic waitDone(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clock);
            if (DoneA || DoneB) seen = 1'b1;
        end
    endtask

    // Drives one complete transaction; the requester's Req must already be high.
    task automatic runTxn(input string tag, input bit isB, input logic [6:0] addr,
                          input logic [7:0] data, input int busyLen, input bit err,
                          input int expLat);
        bit seen;
        int lat;
        expQ.push_back({isB, !isB, err});
        waitGo(400, seen, lat);
        checkEq({tag, "_go_seen"}, seen, 1);
        if (!seen) return;
        if (expLat >= 0) checkEq({tag, "_go_latency"}, lat, expLat);
        checkEq({tag, "_gnt"}, {GntB, GntA}, isB ? 2'b10 : 2'b01);
        checkEq({tag, "_txaddr"}, TxAddr, addr);
        checkEq({tag, "_txdata"}, TxData, data);
        @(negedge clock);
        checkEq({tag, "_go_width"}, Go, 0);
        Busy = 1'b1;
        repeat (busyLen) @(negedge clock);
        Busy = 1'b0;
        AckError = err;
        waitDone(4, seen);
        checkEq({tag, "_done_seen"}, seen, 1);
        AckError = 1'b0;
    endtask

    initial begin
        bit seen;
        int lat;
        int count;
        int goCount;
        AddrA = '0; DataA = '0; AddrB = '0; DataB = '0;

        // 1: sole requester A, then a fresh request must wait out the holdoff
        resetDut();
        AddrA = 7'h3C; DataA = 8'hA5; ReqA = 1'b1;
        runTxn("t1", 1'b0, 7'h3C, 8'hA5, 20, 1'b0, 1);
        runTxn("t1_holdoff", 1'b0, 7'h3C, 8'hA5, 3, 1'b0, HOLDOFF_CYCLES + 2);
        ReqA = 1'b0;

        // 2: both requesting for three rounds alternates A, B, A
        resetDut();
        AddrA = 7'h10; DataA = 8'h01; AddrB = 7'h20; DataB = 8'h02;
        ReqA = 1'b1; ReqB = 1'b1;
        runTxn("t2_r1", 1'b0, 7'h10, 8'h01, 4, 1'b0, 1);
        runTxn("t2_r2", 1'b1, 7'h20, 8'h02, 4, 1'b0, HOLDOFF_CYCLES + 2);
        runTxn("t2_r3", 1'b0, 7'h10, 8'h01, 4, 1'b0, HOLDOFF_CYCLES + 2);
        ReqA = 1'b0; ReqB = 1'b0;

        // 3: NACK from the slave
        resetDut();
        AddrB = 7'h55; DataB = 8'h5A; ReqB = 1'b1;
`ifdef I2C_ARB_RETRY_EN
        expQ.push_back(3'b101);
        goCount = 0;
        for (int a = 0; a <= MAX_RETRY; a++) begin
            waitGo(400, seen, lat);
            if (seen) goCount++;
            @(negedge clock);
            Busy = 1'b1;
            repeat (6) @(negedge clock);
            Busy = 1'b0;
            AckError = 1'b1;
            waitDone(3, seen);
            AckError = 1'b0;
            checkEq("t3_retry_done", seen, (a == MAX_RETRY) ? 1 : 0);
        end
        checkEq("t3_go_count", goCount, MAX_RETRY + 1);
`else
        runTxn("t3", 1'b1, 7'h55, 8'h5A, 6, 1'b1, 1);
`endif
        ReqB = 1'b0;

        // 4: Busy never rises, timeout after TIMEOUT_CYCLES with a single Go
        resetDut();
        AddrA = 7'h01; DataA = 8'h02; ReqA = 1'b1;
        expQ.push_back(3'b011);
        waitGo(10, seen, lat);
        checkEq("t4_go_seen", seen, 1);
        count = 0; goCount = 0; seen = 1'b0;
        for (int i = 0; i < TIMEOUT_CYCLES + 50 && !seen; i++) begin
            @(negedge clock);
            count++;
            if (Go) goCount++;
            if (DoneA || DoneB) seen = 1'b1;
        end
        checkEq("t4_done_seen", seen, 1);
        checkEq("t4_timeout_cycles", count, TIMEOUT_CYCLES);
        checkEq("t4_extra_go", goCount, 0);
        ReqA = 1'b0;

        // 5: reset while waiting for Busy to fall, then a normal B transaction
        resetDut();
        AddrA = 7'h0A; DataA = 8'h0B; ReqA = 1'b1;
        waitGo(10, seen, lat);
        checkEq("t5_go_seen", seen, 1);
        @(negedge clock);
        Busy = 1'b1;
        repeat (3) @(negedge clock);
        Reset = 1'b1; ReqA = 1'b0;
        @(negedge clock);
        checkEq("t5_after_reset", {GntA, GntB, Go, DoneA, DoneB, DebugState}, 0);
        Reset = 1'b0; Busy = 1'b0;
        repeat (5) @(negedge clock);
        AddrB = 7'h44; DataB = 8'h99; ReqB = 1'b1;
        runTxn("t5_b", 1'b1, 7'h44, 8'h99, 4, 1'b0, 1);
        ReqB = 1'b0;

        // 6: requester drops Req and changes its data after grant
        resetDut();
        AddrA = 7'h11; DataA = 8'h22; ReqA = 1'b1;
        expQ.push_back(3'b010);
        waitGo(10, seen, lat);
        checkEq("t6_go_seen", seen, 1);
        ReqA = 1'b0; AddrA = 7'h7F; DataA = 8'hFF;
        @(negedge clock);
        Busy = 1'b1;
        repeat (5) @(negedge clock);
        checkEq("t6_txdata_held", TxData, 8'h22);
        checkEq("t6_txaddr_held", TxAddr, 7'h11);
        checkEq("t6_gnt_held", GntA, 1);
        Busy = 1'b0;
        waitDone(4, seen);
        checkEq("t6_done_seen", seen, 1);

        // 7: Busy already high in IDLE blocks the grant
        resetDut();
        AddrB = 7'h33; DataB = 8'h44; Busy = 1'b1; ReqB = 1'b1;
        goCount = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (Go || GntB) goCount++;
        end
        checkEq("t7_no_grant_busy", goCount, 0);
        Busy = 1'b0;
        runTxn("t7", 1'b1, 7'h33, 8'h44, 4, 1'b0, 1);
        ReqB = 1'b0;

        repeat (5) @(negedge clock);
        checkEq("gnt_onehot", gntViol, 0);
        checkEq("done_onehot", doneViol, 0);
        checkEq("missing_done", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
